// File: rtl/ahb_read_scheduler.sv
// Round-robin arbiter/sequencer sharing one AHB read master between NREQ requesters.
// Optional watchdog on the BUSY wait: define AHB_RD_SCHED_WATCHDOG_EN.
module ahb_read_scheduler #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned ADDRESSWIDTH = 32,
  parameter int unsigned IDW          = 2,
  parameter int unsigned WDOG_CYCLES  = 4096
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*ADDRESSWIDTH-1:0] req_base,
  input  logic [NREQ*ADDRESSWIDTH-1:0] req_length,
  input  logic [NREQ*3-1:0]            req_size,
  input  logic [NREQ-1:0]              req_fixed,
  output logic [NREQ-1:0]              done,
  output logic [NREQ-1:0]              err,
  output logic [IDW-1:0]               owner,
  output logic                         owner_valid,
  output logic                         control_go,
  output logic [ADDRESSWIDTH-1:0]      control_read_base,
  output logic [ADDRESSWIDTH-1:0]      control_read_length,
  output logic                         control_fixed_location,
  output logic [2:0]                   data_size,
  input  logic                         control_done,
  input  logic                         abort
`ifdef AHB_RD_SCHED_WATCHDOG_EN
  ,
  output logic                         timeout
`endif
);

  localparam int unsigned AW = ADDRESSWIDTH;
  localparam int unsigned SW = 3;

  if ((2 ** IDW) < NREQ || WDOG_CYCLES == 0) begin : g_bad_param
    $error("ahb_read_scheduler: IDW too narrow for NREQ or zero WDOG_CYCLES");
  end

  typedef enum logic [1:0] {S_IDLE, S_GO, S_BUSY, S_FINISH} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;
  logic            control_go_q, control_go_d;
  logic            owner_valid_q, owner_valid_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW-1:0]   length_q, length_d;
  logic            fixed_q, fixed_d;
  logic [SW-1:0]   size_q, size_d;

`ifdef AHB_RD_SCHED_WATCHDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);
  logic [15:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d;
`endif

  logic            pick_found_c;
  logic [IDW-1:0]  pick_idx_c;
  logic [NREQ-1:0] pick_onehot_c;
  logic [NREQ-1:0] owner_onehot_c;
  logic [AW-1:0]   sel_base_c;
  logic [AW-1:0]   sel_length_c;
  logic [SW-1:0]   sel_size_c;
  logic            sel_fixed_c;
  logic [1:0]      align_mask_c;
  logic            desc_bad_c;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
    if (idx == IDW'(NREQ - 1)) return '0;
    return idx + IDW'(1);
  endfunction

  // First set request at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    pick_found_c = 1'b0;
    pick_idx_c   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!pick_found_c && req[i] && (i == (int'(rr_ptr_q) + k) % int'(NREQ))) begin
          pick_found_c = 1'b1;
          pick_idx_c   = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    sel_base_c     = '0;
    sel_length_c   = '0;
    sel_size_c     = '0;
    sel_fixed_c    = 1'b0;
    pick_onehot_c  = '0;
    owner_onehot_c = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick_idx_c == IDW'(i)) begin
        sel_base_c       = req_base[i*AW +: AW];
        sel_length_c     = req_length[i*AW +: AW];
        sel_size_c       = req_size[i*SW +: SW];
        sel_fixed_c      = req_fixed[i];
        pick_onehot_c[i] = 1'b1;
      end
      owner_onehot_c[i] = (owner_q == IDW'(i));
    end
  end

  // Length must be non-zero and a whole number of beats of the requested size.
  always_comb begin
    case (sel_size_c)
      3'd0:    align_mask_c = 2'b00;
      3'd1:    align_mask_c = 2'b01;
      default: align_mask_c = 2'b11;
    endcase
    desc_bad_c = (sel_length_c == '0) || (sel_size_c > 3'd2) ||
                 ((sel_length_c[1:0] & align_mask_c) != 2'b00);
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    done_d        = '0;
    err_d         = '0;
    control_go_d  = 1'b0;
    owner_valid_d = owner_valid_q;
    base_d        = base_q;
    length_d      = length_q;
    fixed_d       = fixed_q;
    size_d        = size_q;
`ifdef AHB_RD_SCHED_WATCHDOG_EN
    wdog_d        = wdog_q;
    timeout_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_found_c) begin
          owner_d  = pick_idx_c;
          base_d   = sel_base_c;
          length_d = sel_length_c;
          fixed_d  = sel_fixed_c;
          size_d   = sel_size_c;
          if (desc_bad_c) begin
            err_d    = pick_onehot_c;
            rr_ptr_d = next_idx(pick_idx_c);
          end else begin
            state_d       = S_GO;
            control_go_d  = 1'b1;
            owner_valid_d = 1'b1;
`ifdef AHB_RD_SCHED_WATCHDOG_EN
            wdog_d        = '0;
`endif
          end
        end
      end
      // Master's length counter is stale here, so done/abort are not sampled.
      S_GO: state_d = S_BUSY;
      S_BUSY: begin
        if (abort || control_done) begin
          state_d       = S_FINISH;
          owner_valid_d = 1'b0;
          rr_ptr_d      = next_idx(owner_q);
          if (abort) err_d = owner_onehot_c;
          else       done_d = owner_onehot_c;
        end
`ifdef AHB_RD_SCHED_WATCHDOG_EN
        else if (wdog_q == WDOG_LAST) begin
          state_d       = S_FINISH;
          owner_valid_d = 1'b0;
          rr_ptr_d      = next_idx(owner_q);
          err_d         = owner_onehot_c;
          timeout_d     = 1'b1;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      done_q        <= '0;
      err_q         <= '0;
      control_go_q  <= 1'b0;
      owner_valid_q <= 1'b0;
      base_q        <= '0;
      length_q      <= '0;
      fixed_q       <= 1'b0;
      size_q        <= 3'b010;
`ifdef AHB_RD_SCHED_WATCHDOG_EN
      wdog_q        <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      done_q        <= done_d;
      err_q         <= err_d;
      control_go_q  <= control_go_d;
      owner_valid_q <= owner_valid_d;
      base_q        <= base_d;
      length_q      <= length_d;
      fixed_q       <= fixed_d;
      size_q        <= size_d;
`ifdef AHB_RD_SCHED_WATCHDOG_EN
      wdog_q        <= wdog_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign done                   = done_q;
  assign err                    = err_q;
  assign owner                  = owner_q;
  assign owner_valid            = owner_valid_q;
  assign control_go             = control_go_q;
  assign control_read_base      = base_q;
  assign control_read_length    = length_q;
  assign control_fixed_location = fixed_q;
  assign data_size              = size_q;
`ifdef AHB_RD_SCHED_WATCHDOG_EN
  assign timeout                = timeout_q;
`endif

endmodule

// File: tb/tb_ahb_read_scheduler.sv
// Directed bench for ahb_read_scheduler; also exercises the watchdog when
// AHB_RD_SCHED_WATCHDOG_EN is defined.
module tb_ahb_read_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned IDW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_base;
  logic [NREQ*AW-1:0] req_length;
  logic [NREQ*3-1:0] req_size;
  logic [NREQ-1:0]   req_fixed;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   err;
  logic [IDW-1:0]    owner;
  logic              owner_valid;
  logic              control_go;
  logic [AW-1:0]     control_read_base;
  logic [AW-1:0]     control_read_length;
  logic              control_fixed_location;
  logic [2:0]        data_size;
  logic              control_done;
  logic              abort;
`ifdef AHB_RD_SCHED_WATCHDOG_EN
  logic              timeout;
`endif

  ahb_read_scheduler #(
    .NREQ(NREQ), .ADDRESSWIDTH(AW), .IDW(IDW)
`ifdef AHB_RD_SCHED_WATCHDOG_EN
    , .WDOG_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_base(req_base),
    .req_length(req_length), .req_size(req_size), .req_fixed(req_fixed),
    .done(done), .err(err), .owner(owner), .owner_valid(owner_valid),
    .control_go(control_go), .control_read_base(control_read_base),
    .control_read_length(control_read_length),
    .control_fixed_location(control_fixed_location), .data_size(data_size),
    .control_done(control_done), .abort(abort)
`ifdef AHB_RD_SCHED_WATCHDOG_EN
    , .timeout(timeout)
`endif
  );

  int tests  = 0;
  int fails  = 0;
  int go_cnt = 0;
  int go_ref = 0;

  logic [AW-1:0] tb_base  [NREQ];
  logic [AW-1:0] tb_len   [NREQ];
  logic [2:0]    tb_size  [NREQ];
  logic          tb_fixed [NREQ];

  always @(negedge clk) if (control_go === 1'b1) go_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_desc();
    for (int i = 0; i < int'(NREQ); i++) begin
      req_base[i*AW +: AW]   = tb_base[i];
      req_length[i*AW +: AW] = tb_len[i];
      req_size[i*3 +: 3]     = tb_size[i];
      req_fixed[i]           = tb_fixed[i];
    end
  endtask

  // Decision in IDLE, GO, busy_n BUSY cycles, FINISH with status, back to IDLE.
  task automatic run_xfer(input int own, input int busy_n, input logic use_abort,
                          input logic [NREQ-1:0] req_after);
    logic [NREQ-1:0] vec;
    vec = 4'b0001 << own;
    step();
    chk("go_pulse", control_go, 1);
    chk("owner", owner, own);
    chk("owner_valid_go", owner_valid, 1);
    chk("base", control_read_base, tb_base[own]);
    chk("length", control_read_length, tb_len[own]);
    chk("size", data_size, tb_size[own]);
    chk("fixed", control_fixed_location, tb_fixed[own]);
    step();
    chk("go_single", control_go, 0);
    chk("owner_valid_busy", owner_valid, 1);
    repeat (busy_n - 1) step();
    chk("no_early_status", done | err, 0);
    if (use_abort) abort = 1'b1;
    else           control_done = 1'b1;
    step();
    chk(use_abort ? "err_vec" : "done_vec", use_abort ? err : done, vec);
    chk(use_abort ? "no_done" : "no_err", use_abort ? done : err, 0);
    chk("owner_valid_fin", owner_valid, 0);
    abort = 1'b0;
    control_done = 1'b0;
    req = req_after;
    step();
    chk("status_one_cycle", done | err, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    req = '0;
    control_done = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      tb_base[i]  = 32'h1000 + 32'(i) * 32'h100;
      tb_len[i]   = 32'd16 * 32'(i + 1);
      tb_fixed[i] = (i == 3);
    end
    tb_size[0] = 3'd2; tb_size[1] = 3'd2; tb_size[2] = 3'd1; tb_size[3] = 3'd0;
    apply_desc();
    step();
    step();

    // Reset values
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_go", control_go, 0);
    chk("rst_owner_valid", owner_valid, 0);
    chk("rst_owner", owner, 0);
    chk("rst_base", control_read_base, 0);
    chk("rst_length", control_read_length, 0);
    chk("rst_fixed", control_fixed_location, 0);
    chk("rst_size", data_size, 3'b010);
    reset_n = 1'b1;

    // Single request: base 0x1000, length 16, size 2, done 5 cycles after go
    req = 4'b0001;
    run_xfer(0, 5, 1'b0, 4'b0000);
    chk("single_go_count", go_cnt, 1);
    chk("single_idle_ov", owner_valid, 0);

    // Synchronous reset during BUSY (rr_ptr is 1, so requester 1 is granted)
    req = 4'b0010;
    step();
    chk("mid_go", control_go, 1);
    chk("mid_owner", owner, 1);
    step();
    chk("mid_busy_ov", owner_valid, 1);
    reset_n = 1'b0;
    step();
    chk("mid_rst_ov", owner_valid, 0);
    chk("mid_rst_owner", owner, 0);
    chk("mid_rst_base", control_read_base, 0);
    chk("mid_rst_length", control_read_length, 0);
    chk("mid_rst_size", data_size, 3'b010);
    chk("mid_rst_status", done | err, 0);
    chk("mid_rst_go", control_go, 0);
    reset_n = 1'b1;
    req = 4'b0000;
    step();
    chk("mid_post_status", done | err, 0);
    chk("mid_post_ov", owner_valid, 0);

    // Fairness: all four held, order 0,1,2,3,0
    req = 4'b1111;
    run_xfer(0, 1, 1'b0, 4'b1111);
    run_xfer(1, 1, 1'b0, 4'b1111);
    run_xfer(2, 1, 1'b0, 4'b1111);
    run_xfer(3, 1, 1'b0, 4'b1111);
    run_xfer(0, 1, 1'b0, 4'b0000);

    // Abort on requester 2, then requester 3 wins over 0 and 1
    req = 4'b0100;
    run_xfer(2, 2, 1'b1, 4'b1011);
    run_xfer(3, 1, 1'b0, 4'b0000);

    // Rejection: zero length, then misaligned length
    go_ref = go_cnt;
    tb_len[1] = 32'd0;
    apply_desc();
    req = 4'b0010;
    step();
    chk("rej0_err", err, 4'b0010);
    chk("rej0_go", control_go, 0);
    chk("rej0_ov", owner_valid, 0);
    chk("rej0_owner", owner, 1);
    req = 4'b0000;
    step();
    chk("rej0_err_clear", err, 0);
    tb_len[1] = 32'd6;
    apply_desc();
    req = 4'b0010;
    step();
    chk("rej6_err", err, 4'b0010);
    chk("rej6_go", control_go, 0);
    chk("rej6_length", control_read_length, 6);
    req = 4'b0000;
    step();
    chk("rej6_err_clear", err, 0);
    chk("rej_no_go", go_cnt, go_ref);
    tb_len[1] = 32'd32;
    apply_desc();
    req = 4'b0001;
    run_xfer(0, 1, 1'b0, 4'b0000);

    // Collisions: stale done during GO, then abort and done together
    req = 4'b0100;
    step();
    chk("col_go", control_go, 1);
    chk("col_owner", owner, 2);
    control_done = 1'b1;
    step();
    chk("col_stale_done", done, 0);
    chk("col_still_busy", owner_valid, 1);
    control_done = 1'b0;
    step();
    chk("col_wait_busy", owner_valid, 1);
    chk("col_wait_status", done | err, 0);
    abort = 1'b1;
    control_done = 1'b1;
    step();
    chk("col_both_err", err, 4'b0100);
    chk("col_both_nodone", done, 0);
    abort = 1'b0;
    control_done = 1'b0;
    req = 4'b0000;
    step();
    chk("col_err_clear", err, 0);

`ifdef AHB_RD_SCHED_WATCHDOG_EN
    // Watchdog: master never answers, err+timeout 8 cycles after BUSY entry
    req = 4'b0001;
    step();
    chk("wd_owner", owner, 0);
    step();
    for (int c = 1; c < 8; c++) begin
      step();
      chk("wd_quiet", {timeout, err}, 0);
    end
    step();
    chk("wd_err", err, 4'b0001);
    chk("wd_timeout", timeout, 1);
    req = 4'b0000;
    step();
    chk("wd_timeout_clear", timeout, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_read_scheduler.md
Name: ahb_read_scheduler

Overview:
- Round-robin arbiter and sequencer that shares one AHB read master between NREQ requesters.
- Latches the winning request's descriptor, drives the master's control_* inputs, and pulses control_go for one cycle.
- Waits for control_done or abort, then returns per-requester done/error status.
- Exposes the owner index so the read-data FIFO outputs (user_buffer_data, user_data_available, user_read_buffer) can be demuxed to the owner.

Parameters:
- NREQ, 4, number of requesters (2..8)
- ADDRESSWIDTH, 32, address and length width
- IDW, 2, width of the owner index; must satisfy 2**IDW >= NREQ
- WDOG_CYCLES, 4096, watchdog limit in clocks (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- req  in  NREQ  per-requester request; level, held until done or err
- req_base  in  NREQ*ADDRESSWIDTH  flattened start addresses; slice i = bits [i*AW +: AW]
- req_length  in  NREQ*ADDRESSWIDTH  flattened byte lengths
- req_size  in  NREQ*3  flattened HSIZE codes (0, 1 or 2)
- req_fixed  in  NREQ  fixed-location flag per requester
- done  out  NREQ  one-cycle pulse: transfer for requester i completed
- err  out  NREQ  one-cycle pulse: transfer for requester i aborted or rejected
- owner  out  IDW  index of the current or last granted requester
- owner_valid  out  1  high while a transfer is in flight
- control_go  out  1  start pulse to the read master
- control_read_base  out  ADDRESSWIDTH  latched base address
- control_read_length  out  ADDRESSWIDTH  latched length
- control_fixed_location  out  1  latched fixed flag
- data_size  out  3  latched size code
- control_done  in  1  read master done indication
- abort  in  1  read master error indication

Behaviour:
- Reset (reset_n low at a clk edge):
  - state=IDLE, rr_ptr=0.
  - All outputs 0: done, err, control_go, owner_valid, owner, control_read_base, control_read_length, control_fixed_location.
  - data_size=3'b010.
- States: IDLE, GO, BUSY, FINISH.
- IDLE:
  - If any req bit is set, pick the first set bit at or after rr_ptr, wrapping modulo NREQ.
  - Latch that requester's slices into the control_* registers and data_size; owner=index.
  - Validate the descriptor:
    - invalid if length==0, req_size>2, or length is not a multiple of (1<<req_size);
    - if invalid: pulse err[index] next cycle, advance rr_ptr to index+1, stay IDLE, control_go stays 0.
  - If valid: go to GO.
- GO:
  - control_go=1 for exactly this one cycle; owner_valid=1.
  - control_done and abort are ignored in this cycle, because the master's length counter is still stale.
  - Next state is BUSY.
- BUSY:
  - owner_valid=1.
  - abort=1 goes to FINISH with err[owner] set.
  - Otherwise control_done=1 goes to FINISH with done[owner] set.
  - If both are high in the same cycle, abort wins.
- FINISH:
  - done or err pulses for one cycle; owner_valid=0; rr_ptr=owner+1 mod NREQ.
  - Next state is IDLE.
  - Minimum turnaround from one grant to the next is 4 cycles (IDLE, GO, ≥1 BUSY, FINISH).
- Arbitration latency: a request arriving in IDLE gets control_go asserted 1 cycle after the decision cycle.
- Requests:
  - A req deasserted while its own transfer is in flight does not cancel the transfer; status still pulses.
  - Requesters must hold their descriptor stable until req is sampled in IDLE; the values are registered at that point.
- Control fields hold their values after FINISH until the next grant.
- Wrap-around: rr_ptr is a modulo-NREQ counter; the highest index wraps to 0.
- Synchronous reset mid-transfer returns to IDLE with no done or err pulse. The master is reset by the same reset_n.

Optional Feature:
- Macro: AHB_RD_SCHED_WATCHDOG_EN.
- Defined:
  - A 16-bit counter clears on entry to GO and counts in BUSY.
  - When it reaches WDOG_CYCLES with neither control_done nor abort, go to FINISH and pulse err[owner].
  - Extra output timeout (1 bit) pulses together with that err.
- Undefined:
  - BUSY waits indefinitely.
  - No counter and no timeout port.

Test Plan:
- Single request:
  - Stimulus: req=0001, base=0x1000, length=16, size=2; master model returns done 5 cycles after go.
  - Required: exactly one control_go, control_read_base=0x1000, control_read_length=16, then done=0001 pulse; owner_valid low afterwards.
- Fairness:
  - Stimulus: req=1111 held continuously, each transfer completes.
  - Required: grant order 0,1,2,3,0; no requester granted twice before all others.
- Abort:
  - Stimulus: master asserts abort 2 cycles after go for requester 2.
  - Required: err=0100 pulse, no done; next grant goes to requester 3.
- Rejection:
  - Stimulus: requester 1 with length=0; requester 1 with length=6, size=2.
  - Required: err=0010 pulse, control_go never asserts, arbitration continues.
- Collisions:
  - Stimulus: control_done held high during GO (stale).
  - Required: ignored, transfer still waits in BUSY.
  - Stimulus: abort and done high in the same BUSY cycle.
  - Required: err pulse only.
- Reset and watchdog:
  - Stimulus: reset_n low for 1 cycle during BUSY.
  - Required: next cycle state IDLE, all outputs 0, no status pulse.
  - Stimulus (with AHB_RD_SCHED_WATCHDOG_EN, WDOG_CYCLES=8): master never responds.
  - Required: err and timeout pulse exactly 8 cycles after entering BUSY.
